data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 93 +++++++++
 tb/tb_data_mem_responder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: word/byte RAM responder with a fixed-latency valid/ready handshake.
// Define DATA_MEM_RESPONDER_ERR_EN to flag misaligned, out-of-range and malformed accesses.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        sw,
  input  logic        sb,
  input  logic        lw,
  input  logic        lbu,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] read_data,
  output logic        error
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [31:0] addr_q, wdata_q;
  logic [3:0] op_q;
  logic [31:0] mem [DEPTH_WORDS];
  logic idle, accept, enter, bad, we, unused_hi;
  logic [31:0] a, d, wd, word;
  logic [3:0] op, be;
  logic [AW-1:0] idx;
  logic [1:0] lane;
  assign req_ready = state == IDLE;
  // In IDLE the live inputs are used so a zero-wait access can complete on its accept edge.
  always_comb begin
    idle = state == IDLE;
    accept = idle && req_valid;
    enter = accept ? WAIT_CYCLES == 0 : state == WAIT && cnt == 4'd0;
    a = idle ? addr : addr_q;
    d = idle ? write_data : wdata_q;
    op = idle ? {sw, sb, lw, lbu} : op_q;
    idx = a[AW+1:2];
    lane = a[1:0];
    word = mem[idx];
`ifdef DATA_MEM_RESPONDER_ERR_EN
    bad = !$onehot(op) || ((op[3] || op[1]) && lane != 2'd0) || a >= 32'(DEPTH_WORDS * 4);
`else
    bad = !$onehot(op);
`endif
    we = enter && !bad && (op[3] || op[2]);
    be = op[3] ? 4'hf : 4'b0001 << lane;
    wd = op[2] ? {4{d[7:0]}} : d;
    unused_hi = ^a[31:AW+2];
  end
  always_ff @(posedge clk)
    if (we && !rst)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      resp_valid <= 1'b0;
      read_data <= 32'd0;
      error <= 1'b0;
    end else begin
      if (accept) begin
        addr_q <= addr;
        wdata_q <= write_data;
        op_q <= {sw, sb, lw, lbu};
        state <= WAIT_CYCLES == 0 ? RESP : WAIT;
        cnt <= 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
      end else if (state == WAIT) begin
        if (cnt == 4'd0) state <= RESP;
        else cnt <= cnt - 4'd1;
      end else if (state == RESP && resp_ready) state <= IDLE;
      if (enter) begin
        resp_valid <= 1'b1;
        read_data <= bad ? 32'd0 : op[1] ? word : op[0] ? {24'd0, word[{lane, 3'b000} +: 8]} : 32'd0;
`ifdef DATA_MEM_RESPONDER_ERR_EN
        error <= bad;
`else
        error <= 1'b0;
`endif
      end else if (state == RESP && resp_ready) begin
        resp_valid <= 1'b0;
        read_data <= 32'd0;
        error <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed bench with a transaction-level memory model checked every cycle.
module tb_data_mem_responder;
  localparam int W = 2;
  localparam int DEPTH = 256;
`ifdef DATA_MEM_RESPONDER_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, resp_ready = 1'b0, req_valid0 = 1'b0, resp_ready0 = 1'b0;
  logic [31:0] addr = 32'd0, write_data = 32'd0;
  logic sw = 1'b0, sb = 1'b0, lw = 1'b0, lbu = 1'b0;
  logic req_ready, resp_valid, error, req_ready0, resp_valid0, error0;
  logic [31:0] read_data, read_data0;
  int total = 0, bad = 0;
  bit chk_on = 1'b0;
  always #5 clk = ~clk;
  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .addr(addr),
    .write_data(write_data), .sw(sw), .sb(sb), .lw(lw), .lbu(lbu), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .read_data(read_data), .error(error));
  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0), .addr(addr),
    .write_data(write_data), .sw(sw), .sb(sb), .lw(lw), .lbu(lbu), .resp_valid(resp_valid0),
    .resp_ready(resp_ready0), .read_data(read_data0), .error(error0));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask
  // Reference model: one outstanding access, executed against a plain word array once its wait elapses.
  logic [31:0] mem_m [DEPTH];
  bit m_busy = 1'b0;
  int m_k = 0;
  logic [3:0] m_op;
  logic [31:0] m_a, m_d, m_rd;
  logic m_er;
  task automatic exec();
    int n, wi, ln;
    bit fault;
    n = int'(m_op[3]) + int'(m_op[2]) + int'(m_op[1]) + int'(m_op[0]);
    wi = int'((m_a / 4) % DEPTH);
    ln = int'(m_a % 4);
    fault = n != 1;
    if (ERR && ((m_op[3] || m_op[1]) && ln != 0)) fault = 1'b1;
    if (ERR && m_a >= DEPTH * 4) fault = 1'b1;
    m_er = ERR && fault;
    m_rd = 32'd0;
    if (!fault) begin
      if (m_op[3]) mem_m[wi] = m_d;
      if (m_op[2]) mem_m[wi][8*ln +: 8] = m_d[7:0];
      if (m_op[1]) m_rd = mem_m[wi];
      if (m_op[0]) m_rd = (mem_m[wi] >> (8 * ln)) & 32'hff;
    end
  endtask
  always @(posedge clk) begin
    if (rst) m_busy = 1'b0;
    else if (m_busy) begin
      if (m_k >= W && resp_ready) m_busy = 1'b0;
      else if (m_k < W) begin
        m_k++;
        if (m_k == W) exec();
      end
    end else if (req_valid) begin
      m_busy = 1'b1;
      m_k = 0;
      m_op = {sw, sb, lw, lbu};
      m_a = addr;
      m_d = write_data;
      if (W == 0) exec();
    end
  end
  always @(negedge clk)
    if (chk_on) begin
      chk("m_req_ready", 32'(req_ready), 32'(!m_busy));
      chk("m_resp_valid", 32'(resp_valid), 32'(m_busy && m_k >= W));
      if (resp_valid) begin
        chk("m_read_data", read_data, m_rd);
        chk("m_error", 32'(error), 32'(m_er));
      end
    end
  task automatic wait_resp(input string nm, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 20);
    chk({nm, "_resp_seen"}, 32'(resp_valid), 32'd1);
  endtask
  task automatic xact(input string nm, input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                      input int hold, input logic [31:0] exp_rd, input logic exp_er);
    int n;
    @(posedge clk); #1;
    req_valid = 1'b1; {sw, sb, lw, lbu} = op; addr = a; write_data = d;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (req_ready) break;
      if (++n > 20) begin
        total++; bad++;
        $display("FAIL %s accept timeout", nm);
        req_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0; addr = $urandom; write_data = $urandom; {sw, sb, lw, lbu} = 4'($urandom);
    wait_resp(nm, n);
    chk({nm, "_latency"}, 32'(n), 32'(W + 1));
    chk({nm, "_rd"}, read_data, exp_rd);
    chk({nm, "_err"}, 32'(error), 32'(exp_er));
    repeat (hold) begin
      @(negedge clk);
      chk({nm, "_hold_rv"}, 32'(resp_valid), 32'd1);
      chk({nm, "_hold_rd"}, read_data, exp_rd);
      chk({nm, "_hold_rr"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    chk({nm, "_done_rr"}, 32'(req_ready), 32'd1);
    chk({nm, "_done_rv"}, 32'(resp_valid), 32'd0);
  endtask
  initial begin
    #300000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int n, acc;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk_on = 1'b1;
    xact("sw0", 4'b1000, 32'h0, 32'h11223344, 0, 32'd0, 1'b0);
    xact("sw10", 4'b1000, 32'h10, 32'hDEADBEEF, 0, 32'd0, 1'b0);
    xact("lw10", 4'b0010, 32'h10, 32'h0, 0, 32'hDEADBEEF, 1'b0);
    xact("sb12", 4'b0100, 32'h12, 32'hFFFFFF55, 0, 32'd0, 1'b0);
    xact("lw10b", 4'b0010, 32'h10, 32'h0, 5, 32'hDE55BEEF, 1'b0);
    xact("lbu13", 4'b0001, 32'h13, 32'h0, 0, 32'h000000DE, 1'b0);
    xact("sw20", 4'b1000, 32'h20, 32'hCAFEF00D, 0, 32'd0, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b1; {sw, sb, lw, lbu} = 4'b1000; addr = 32'h20; write_data = 32'h12345678;
    @(negedge clk);
    chk("abort_pre_rr", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("abort_rv", 32'(resp_valid), 32'd0);
    end
    xact("lw20", 4'b0010, 32'h20, 32'h0, 0, 32'hCAFEF00D, 1'b0);
    if (ERR) begin
      xact("lw02_err", 4'b0010, 32'h02, 32'h0, 0, 32'd0, 1'b1);
      xact("sw400_err", 4'b1000, 32'h400, 32'hA5, 0, 32'd0, 1'b1);
      xact("lw0_keep", 4'b0010, 32'h0, 32'h0, 0, 32'h11223344, 1'b0);
    end else begin
      xact("sw400_wrap", 4'b1000, 32'h400, 32'hA5, 0, 32'd0, 1'b0);
      xact("lw0_wrap", 4'b0010, 32'h0, 32'h0, 0, 32'h000000A5, 1'b0);
      xact("lw12_align", 4'b0010, 32'h12, 32'h0, 0, 32'hDE55BEEF, 1'b0);
    end
    xact("noop", 4'b0000, 32'h10, 32'h0, 0, 32'd0, ERR);
    xact("multi", 4'b1010, 32'h10, 32'h0, 0, 32'd0, ERR);
    xact("lw10c", 4'b0010, 32'h10, 32'h0, 0, 32'hDE55BEEF, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b1; {sw, sb, lw, lbu} = 4'b0010; addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_resp("b2e_first", n);
    resp_ready = 1'b1; req_valid = 1'b1;
    @(negedge clk);
    chk("no_accept_on_done_rr", 32'(req_ready), 32'd1);
    chk("no_accept_on_done_rv", 32'(resp_valid), 32'd0);
    resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("accept_after_done_rr", 32'(req_ready), 32'd0);
    wait_resp("b2e_second", n);
    chk("b2e_second_rd", read_data, 32'hDE55BEEF);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    {sw, sb, lw, lbu} = 4'b1000; addr = 32'h40; write_data = 32'h0BADF00D;
    req_valid0 = 1'b1; resp_ready0 = 1'b1;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (req_ready0) acc++;
      chk("b2b0_rr", 32'(req_ready0), 32'(i % 2 == 0));
      chk("b2b0_rv", 32'(resp_valid0), 32'(i % 2 == 1));
      if (resp_valid0) chk("b2b0_err", 32'(error0), 32'd0);
    end
    chk("b2b0_accepts", 32'(acc), 32'd5);
    req_valid0 = 1'b0; resp_ready0 = 1'b0;
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
